// File: rtl/bitblade_acc.sv
// bitblade_acc: streaming multi-precision unsigned dot-product accumulator.
// Optional feature macro: BITBLADE_ACC_SAT_EN.
// When it is defined, the accumulator saturates and out_ovf flags the vector.
// When it is undefined, the accumulator wraps and out_ovf is held at 0.
module bitblade_acc #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    output logic             out_ovf
);

    typedef enum logic [1:0] {RUN, HI, DRAIN, HOLD} state_t;

    state_t             r_state, w_next;
    logic               w_accept, w_clear;
    logic [17:0]        w_ps_lo, w_ps_hi;

    // latched high operand halves and last flag for the mode-2 second pass
    logic [31:0]        r_a_hi, r_b_hi;
    logic               r_last;

    // stage 1: partial sum with valid/last tags
    logic [17:0]        r_ps;
    logic               r_ps_vld, r_ps_last;

    // stage 2: accumulator and vector status
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    function automatic logic [17:0] sum_4x8(input logic [31:0] a, input logic [31:0] b);
        logic [17:0] s;
        s = '0;
        for (int unsigned i = 0; i < 4; i++)
            s = s + {2'b00, 16'(a[8*i +: 8]) * 16'(b[8*i +: 8])};
        return s;
    endfunction

    function automatic logic [17:0] sum_16x4(input logic [63:0] a, input logic [63:0] b);
        logic [17:0] s;
        s = '0;
        for (int unsigned i = 0; i < 16; i++)
            s = s + {10'b0, 8'(a[4*i +: 4]) * 8'(b[4*i +: 4])};
        return s;
    endfunction

    assign w_accept = in_valid && (r_state == RUN);
    assign w_clear  = (r_state == HOLD) && out_ready;
    assign w_ps_hi  = sum_4x8(r_a_hi, r_b_hi);

    // first-pass partial sum selected by the beat's precision mode
    always_comb begin
        w_ps_lo = '0;
        case (in_mode)
            2'd0, 2'd2: w_ps_lo = sum_4x8(in_a[31:0], in_b[31:0]);
            2'd1:       w_ps_lo = sum_16x4(in_a, in_b);
            default:    w_ps_lo = '0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_next;
    end

    // next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            RUN: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (in_mode == 2'd2) w_next = HI;
                    else if (in_last)    w_next = DRAIN;
                end
            end
            HI:      w_next = r_last ? DRAIN : RUN;
            DRAIN:   if (r_ps_vld && r_ps_last) w_next = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_next = RUN;
            end
            default: w_next = RUN;
        endcase
    end

    // operand latch for the deferred high pass
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_hi <= '0;
            r_b_hi <= '0;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_a_hi <= in_a[63:32];
            r_b_hi <= in_b[63:32];
            r_last <= in_last;
        end
    end

    // stage 1: register a partial sum from an accepted beat or the high pass
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps      <= '0;
            r_ps_vld  <= 1'b0;
            r_ps_last <= 1'b0;
        end else begin
            r_ps      <= (r_state == HI) ? w_ps_hi : w_ps_lo;
            r_ps_vld  <= w_accept || (r_state == HI);
            r_ps_last <= (w_accept && in_last && (in_mode != 2'd2)) ||
                         ((r_state == HI) && r_last);
        end
    end

`ifdef BITBLADE_ACC_SAT_EN
    logic [ACC_W:0] w_sum;
    logic           r_ovf;
    assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(r_ps);
    assign out_ovf = r_ovf;

    // stage 2: saturating accumulate; clamp sticks once reached
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_ps_vld) begin
            if (w_sum[ACC_W]) begin
                r_acc <= '1;
                r_ovf <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end
`else
    assign out_ovf = 1'b0;

    // stage 2: wrapping accumulate
    always_ff @(posedge clk) begin
        if (reset || w_clear)  r_acc <= '0;
        else if (r_ps_vld)     r_acc <= r_acc + ACC_W'(r_ps);
    end
`endif

    // beat counter (saturating) and reserved-mode error flag
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            if (in_mode == 2'd3) r_err <= 1'b1;
        end
    end

    assign out_data  = r_acc;
    assign out_count = r_cnt;
    assign out_err   = r_err;

endmodule

// File: tb/tb_bitblade_acc.sv
// Testbench for bitblade_acc: two instances (32/16 and 20/4) share stimulus
// and are compared every cycle against a whole-vector arithmetic model.
module tb_bitblade_acc;

`ifdef BITBLADE_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_last, out_ready;
    logic [1:0]  in_mode;
    logic [63:0] in_a, in_b;

    logic        rdy_a, rdy_b, ov_a, ov_b, err_a, err_b, ovf_a, ovf_b;
    logic [31:0] data_a;
    logic [19:0] data_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    bitblade_acc #(.ACC_W(32), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
        .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(data_a),
        .out_count(cnt_a), .out_err(err_a), .out_ovf(ovf_a));

    bitblade_acc #(.ACC_W(20), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
        .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(data_b),
        .out_count(cnt_b), .out_err(err_b), .out_ovf(ovf_b));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // model of the vector in flight
    longint unsigned m_raw = 0;
    int              m_cnt = 0;
    bit              m_err = 1'b0;
    bit              m_pend = 1'b0;
    int              m_rise = 0;
    int              m_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic longint unsigned dot(input int mode, input logic [63:0] a, input logic [63:0] b);
        longint unsigned s = 0;
        case (mode)
            0: for (int i = 0; i < 4; i++)  s += 64'(a[8*i +: 8]) * 64'(b[8*i +: 8]);
            1: for (int i = 0; i < 16; i++) s += 64'(a[4*i +: 4]) * 64'(b[4*i +: 4]);
            2: for (int i = 0; i < 8; i++)  s += 64'(a[8*i +: 8]) * 64'(b[8*i +: 8]);
            default: s = 0;
        endcase
        return s;
    endfunction

    function automatic longint unsigned exp_data(input int w);
        longint unsigned mx = (64'd1 << w) - 1;
        if (SAT) return (m_raw > mx) ? mx : m_raw;
        return m_raw & mx;
    endfunction

    function automatic bit exp_ovf(input int w);
        longint unsigned mx = (64'd1 << w) - 1;
        return SAT && (m_raw > mx);
    endfunction

    // per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        bit ev;
        if (chk_en && !reset) begin
            ev = m_pend && (cyc >= m_rise);
            check("out_valid_a", ov_a, ev);
            check("out_valid_b", ov_b, ev);
            if (ev) begin
                check("out_data_a",  data_a, exp_data(32));
                check("out_data_b",  data_b, exp_data(20));
                check("out_count_a", cnt_a, (m_cnt > 65535) ? 65535 : m_cnt);
                check("out_count_b", cnt_b, (m_cnt > 15) ? 15 : m_cnt);
                check("out_err_a",   err_a, m_err);
                check("out_err_b",   err_b, m_err);
                check("out_ovf_a",   ovf_a, exp_ovf(32));
                check("out_ovf_b",   ovf_b, exp_ovf(20));
            end
        end
    end

    task automatic clear_model();
        m_raw = 0; m_cnt = 0; m_err = 1'b0; m_pend = 1'b0;
    endtask

    // present one beat at a negedge; returns one cycle later (two for mode 2)
    task automatic beat(input int mode, input logic [63:0] a, input logic [63:0] b, input bit last);
        in_valid = 1'b1; in_mode = 2'(mode); in_a = a; in_b = b; in_last = last;
        check("in_ready_a_accept", rdy_a, 1);
        check("in_ready_b_accept", rdy_b, 1);
        m_raw += dot(mode, a, b);
        m_cnt++;
        if (mode == 3) m_err = 1'b1;
        if (last) begin
            m_pend    = 1'b1;
            m_rise    = cyc + ((mode == 2) ? 3 : 2);
            m_acc_cyc = cyc;
        end
        @(negedge clk);
        if (mode == 2) begin
            // junk offered during the high pass must be ignored
            in_valid = 1'b1; in_mode = 2'($urandom_range(0, 3));
            in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_last = 1'($urandom);
            check("in_ready_a_hi", rdy_a, 0);
            check("in_ready_b_hi", rdy_b, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_vector(input int hold, input bit lit,
                                 input longint unsigned la, input longint unsigned lb,
                                 input int lca, input int lcb, input bit lerr,
                                 input bit lovf_b, input int llat);
        int k = 0;
        in_valid = 1'b0;
        while (ov_a !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (ov_a !== 1'b1) check("out_valid_timeout", ov_a, 1);
        if (lit) begin
            check("lit_latency",  cyc - m_acc_cyc, llat);
            check("lit_data_a",   data_a, la);
            check("lit_data_b",   data_b, lb);
            check("lit_count_a",  cnt_a, lca);
            check("lit_count_b",  cnt_b, lcb);
            check("lit_err_a",    err_a, lerr);
            check("lit_ovf_b",    ovf_b, lovf_b);
        end
        repeat (hold) begin
            in_valid = 1'b1; in_mode = 2'($urandom_range(0, 3));
            in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_last = 1'b1;
            check("in_ready_a_hold", rdy_a, 0);
            check("in_ready_b_hold", rdy_b, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        clear_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        @(negedge clk);
        check("rst_in_ready_a",  rdy_a, 1);
        check("rst_out_valid_a", ov_a, 0);
        check("rst_out_data_a",  data_a, 0);
        check("rst_out_count_a", cnt_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, mode, sel;
        logic [63:0] a, b;

        reset = 1'b1; in_valid = 1'b0; in_mode = '0; in_a = '0; in_b = '0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready_a",  rdy_a, 1);
        check("reset_out_valid_a", ov_a, 0);
        check("reset_out_data_a",  data_a, 0);
        check("reset_out_count_a", cnt_a, 0);
        check("reset_out_err_a",   err_a, 0);
        check("reset_out_ovf_a",   ovf_a, 0);
        check("reset_out_data_b",  data_b, 0);
        chk_en = 1'b1;

        // single mode-0 beat
        beat(0, 64'h01020304, 64'h05060708, 1);
        finish_vector(0, 1, 70, 70, 1, 1, 0, 0, 2);

        // single mode-1 beat, all nibbles 0xF
        beat(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        finish_vector(0, 1, 3600, 3600, 1, 1, 0, 0, 2);

        // single mode-2 beat, all bytes 0xFF
        beat(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        finish_vector(0, 1, 520200, 520200, 1, 1, 0, 0, 3);

        // reserved mode mid-vector, consumer stalls 4 cycles
        beat(0, 64'h01020304, 64'h05060708, 0);
        beat(3, 64'h01020304, 64'h05060708, 0);
        beat(0, 64'h01020304, 64'h05060708, 1);
        finish_vector(4, 1, 140, 140, 3, 3, 1, 0, 2);

        // three mode-2 saturating/wrapping beats on the 20-bit instance
        for (int i = 0; i < 3; i++)
            beat(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, i == 2);
        if (SAT) finish_vector(1, 1, 1560600, 20'hFFFFF, 3, 3, 0, 1, 3);
        else     finish_vector(1, 1, 1560600, 512024, 3, 3, 0, 0, 3);

        // count saturation on the 4-bit counter
        for (int i = 0; i < 20; i++)
            beat(1, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, i == 19);
        finish_vector(0, 1, 320, 320, 20, 15, 0, 0, 2);

        // reset after two beats discards the vector
        beat(0, 64'h01020304, 64'h05060708, 0);
        beat(1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0);
        do_reset();
        repeat (3) @(negedge clk);
        beat(0, 64'h01020304, 64'h05060708, 1);
        finish_vector(0, 1, 70, 70, 1, 1, 0, 0, 2);

        // reset while holding a result
        beat(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1);
        for (int k = 0; k < 8 && ov_a !== 1'b1; k++) @(negedge clk);
        check("hold_before_reset", ov_a, 1);
        do_reset();
        repeat (2) @(negedge clk);

        // randomized vectors with mixed modes, gaps and stalls
        for (int v = 0; v < 60; v++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                mode = $urandom_range(0, 3);
                sel  = $urandom_range(0, 3);
                a = (sel == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
                b = (sel == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
                beat(mode, a, b, j == len - 1);
                if (j != len - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            finish_vector($urandom_range(0, 3), 0, 0, 0, 0, 0, 0, 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bitblade_acc.md
BITBLADE_ACC -- requirements
Module: bitblade_acc

Interface
REQ-001 Parameter ACC_W, default 32, accumulator/result width; SHALL be >= 20.
REQ-002 Parameter CNT_W, default 16, beat-counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  beat offered.
REQ-006 in_ready  output  1  block can accept a beat; a beat is accepted on a cycle with in_valid && in_ready.
REQ-007 in_mode  input  2  per-beat precision: 0 = 4x8-bit, 1 = 16x4-bit, 2 = 8x8-bit two-pass, 3 = reserved.
REQ-008 in_a, in_b  input  64 each  packed unsigned operands.
REQ-009 in_last  input  1  beat closes the current dot-product vector.
REQ-010 out_valid  output  1  result held.
REQ-011 out_ready  input  1  consumer accepts result; handshake completes on out_valid && out_ready.
REQ-012 out_data  output  ACC_W  accumulated dot product.
REQ-013 out_count  output  CNT_W  number of beats in the vector.
REQ-014 out_err  output  1  vector contained at least one mode-3 beat.
REQ-015 out_ovf  output  1  accumulator saturated (see Configuration).

Function
REQ-016 Mode 0 SHALL compute the sum over i=0..3 of in_a[8i+7:8i]*in_b[8i+7:8i]; bits 63:32 are ignored.
REQ-017 Mode 1 SHALL compute the sum over i=0..15 of in_a[4i+3:4i]*in_b[4i+3:4i].
REQ-018 Mode 2 SHALL compute the low pass (mode-0 sum of bits 31:0) in the accept cycle and the high pass (same sum on bits 63:32, from latched operands) in the next cycle, as two partial sums.
REQ-019 Mode 3 SHALL contribute 0, SHALL count as a beat, and SHALL set the vector's out_err.
REQ-020 All arithmetic SHALL be unsigned; the partial-sum register SHALL be 18 bits wide, zero-extended into the accumulator.
REQ-021 FSM states: RUN, HI, DRAIN, HOLD.
- RUN: in_ready=1.
- Accept mode 2 -> HI.
- Accept other mode with in_last -> DRAIN.
- Otherwise stay in RUN.
REQ-022 HI: in_ready=0, issue high pass; -> DRAIN if the latched last flag is set, else -> RUN.
REQ-023 DRAIN: in_ready=0, wait for the last partial sum to be accumulated -> HOLD.
REQ-024 HOLD: in_ready=0, out_valid=1; out_data/out_count/out_err/out_ovf SHALL be stable until handshake.
REQ-025 HOLD with out_ready -> RUN next cycle, with accumulator, counter and flags cleared.
REQ-026 Pipeline: stage 1 registers the partial sum with valid/last tags; stage 2 adds it to the accumulator.
REQ-027 Latency: last beat accepted at cycle T -> out_valid at T+2 for modes 0/1/3, at T+3 for mode 2.
REQ-028 Sustained throughput in RUN SHALL be 1 beat/cycle for modes 0/1/3 and 1 beat per 2 cycles for mode 2.
REQ-029 Mode SHALL be sampled per beat; mixed modes within a vector are legal.
REQ-030 out_count SHALL saturate at 2^CNT_W-1.
REQ-031 in_valid while in_ready=0 SHALL have no effect.
REQ-032 A single-beat vector (first beat carries in_last) SHALL be legal.

Reset
REQ-033 On reset:
- State -> RUN; in_ready=1 the following cycle.
- out_valid=0, out_data=0, out_count=0, out_err=0, out_ovf=0.
- Accumulator, pipeline valids and partial sums cleared.
REQ-034 Reset mid-vector or in HOLD SHALL discard the partial result with no output handshake.

Configuration
REQ-035 Macro BITBLADE_ACC_SAT_EN.
- Defined: the accumulator clamps at 2^ACC_W-1 and out_ovf is set for that vector.
- Undefined: the accumulator wraps modulo 2^ACC_W and out_ovf is tied to 0.

Verification
REQ-036 Mode 0, a=0x01020304, b=0x05060708, last -> out_data=70, out_count=1, out_valid at T+2.
REQ-037 Mode 1, a=b=all 0xF, last -> out_data=3600 (0xE10).
REQ-038 Mode 2, a=b=all 0xFF, last -> in_ready=0 at T+1, out_data=520200, out_valid at T+3.
REQ-039 Three mode-0 beats from REQ-036 (mode 3 on the second), out_ready held low 4 cycles -> out_data=140, count=3, out_err=1; outputs stable and in_ready=0 throughout HOLD.
REQ-040 ACC_W=20, three mode-2 all-0xFF beats -> with macro: 0xFFFFF, out_ovf=1; without: 512024, out_ovf=0.
REQ-041 Reset asserted after beat 2 of a vector -> no out_valid; a new single-beat REQ-036 vector yields 70.
